instr_mem_pipe: RTL and testbench
=================================

INSTR_MEM_PIPE -- requirements
Module: instr_mem_pipe

Interface
REQ-001 Parameter DEPTH, default 256, memory depth in 32-bit words; power of two, 16..4096.
REQ-002 Parameter LATENCY, default 1, request-to-response cycles; legal values 1 or 2.
REQ-003 Parameter INIT_WORD, default 32'h00000013, fill value for all words (NOP = ADDI x0,x0,0).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  1  fetch request present.
REQ-007 req_ready  out  1  fetch request accepted this cycle when high with req_valid.
REQ-008 req_addr  in  32  byte address of fetch.
REQ-009 rsp_valid  out  1  response present.
REQ-010 rsp_ready  in  1  consumer takes response this cycle.
REQ-011 rsp_instr  out  32  fetched instruction word.
REQ-012 rsp_fault  out  1  request was misaligned or out of range.
REQ-013 ld_en  in  1  program-load write strobe.
REQ-014 ld_addr  in  32  byte address of load word (bits [1:0] ignored).
REQ-015 ld_data  in  32  load data.
REQ-016 ld_be  in  4  byte enables; bit i writes ld_data[8i+7:8i].
REQ-017 fault_cnt  out  8  saturating count of faulted accepted requests.

Function
REQ-018 Accept = req_valid && req_ready; memory read at the accepting edge, word index req_addr[log2(DEPTH)+1:2].
REQ-019 rsp_valid rises exactly LATENCY cycles after acceptance when the output path is not stalled.
REQ-020 LATENCY=1: one output register; req_ready = !ld_en && (!rsp_valid || rsp_ready).
REQ-021 LATENCY=2: two valid/data stages; each stage loads when next stage empty or advancing; req_ready = !ld_en && (stage1 empty || stage1 advancing); full throughput of one response per cycle with rsp_ready held high.
REQ-022 While rsp_valid && !rsp_ready, rsp_instr and rsp_fault held stable; no response dropped, duplicated or reordered.
REQ-023 Fault when req_addr[1:0] != 0 or req_addr[31:2] >= DEPTH; faulted response returns rsp_instr = INIT_WORD, rsp_fault = 1, memory not indexed.
REQ-024 fault_cnt increments by 1 per accepted faulted request; saturates at 255, no wrap.
REQ-025 ld_en high: bytes selected by ld_be written to word ld_addr[log2(DEPTH)+1:2] at the edge; ld_addr[31:2] >= DEPTH ignored silently; ld_be = 0 writes nothing.
REQ-026 ld_en has priority: req_ready forced low, no request accepted that cycle; pipeline stages already holding data still drain normally.
REQ-027 In-flight responses carry data read at acceptance; later loads to the same word do not alter them.
REQ-028 Request accepted the cycle after a load to the same word returns the newly loaded data.
REQ-029 Memory contents initialised to INIT_WORD at elaboration, not via rst.

Reset
REQ-030 rst asserted: all stage valid bits and rsp_valid = 0, rsp_instr = INIT_WORD, rsp_fault = 0, fault_cnt = 0, immediately (asynchronous).
REQ-031 rst asserted mid-operation discards all in-flight requests; memory contents preserved.
REQ-032 rst deasserted: req_ready = !ld_en on the first cycle.

Structure
REQ-033 Package imem_pkg holds: word typedef (32 bits), byte-enable typedef (4 bits), constant NOP_WORD = 32'h00000013, constant FAULT_CNT_W = 8.
REQ-034 One sub-module imem_pipe_stage (valid + instr + fault register with in/out ready handshake), instantiated LATENCY times.

Verification
REQ-035 Reset, load words 0..3 = 0x11111111..0x44444444 via ld_en, fetch 0x0,0x4,0x8,0xC back-to-back with rsp_ready=1 -> four responses in order, one per cycle, first at LATENCY cycles after first accept.
REQ-036 Fetch 0x8 with rsp_ready=0 for 5 cycles -> rsp_instr=0x33333333 stable, req_ready low once pipeline full, no loss when rsp_ready returns.
REQ-037 Fetch 0x6 and 0x400 (DEPTH=256) -> rsp_fault=1, rsp_instr=0x00000013, fault_cnt=2; 300 faults -> fault_cnt=255.
REQ-038 Load word 1 = 0xAABBCCDD with ld_be=4'b0101 over 0x22222222 -> fetch 0x4 returns 0x22BB22DD; req_ready low during ld_en cycle.
REQ-039 Assert rst with 2 responses in flight (LATENCY=2) -> rsp_valid=0 immediately, no stale response after release, loaded data still readable.
REQ-040 Fetch unloaded word 0x10 after reset -> rsp_instr=0x00000013, rsp_fault=0.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory pipeline.
//   word_t      : 32-bit instruction/data word
//   be_t        : 4-bit byte-enable mask
//   NOP_WORD    : ADDI x0,x0,0, used as fill value and fault response
//   FAULT_CNT_W : width of the saturating fault counter
package imem_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  be_t;

  localparam word_t       NOP_WORD    = 32'h00000013;
  localparam int unsigned FAULT_CNT_W = 8;

endpackage

// File: rtl/imem_pipe_stage.sv
// One pipeline register slot: valid + instruction + fault flag with a
// ready/valid handshake on both sides.
//   clk, rst                     : clock, asynchronous active-high reset
//   in_valid_i / in_ready_o      : upstream handshake
//   in_instr_i / in_fault_i      : upstream payload
//   out_valid_o / out_ready_i    : downstream handshake
//   out_instr_o / out_fault_o    : registered payload, stable while stalled
module imem_pipe_stage
  import imem_pkg::*;
#(
  parameter logic [31:0] INIT_WORD = NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_instr_i,
  input  logic        in_fault_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic        out_fault_o
);

  logic  valid_q;
  word_t instr_q;
  logic  fault_q;

  // Slot can take new data when empty or when its content leaves this cycle.
  assign in_ready_o = !valid_q || out_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= INIT_WORD;
      fault_q <= 1'b0;
    end else if (in_ready_o) begin
      valid_q <= in_valid_i;
      // Payload only changes on a real load so an idle slot keeps its last word.
      if (in_valid_i) begin
        instr_q <= in_instr_i;
        fault_q <= in_fault_i;
      end
    end
  end

  assign out_valid_o = valid_q;
  assign out_instr_o = instr_q;
  assign out_fault_o = fault_q;

endmodule

// File: rtl/instr_mem_pipe.sv
// Instruction memory with a program-load write port and a LATENCY-deep
// (1 or 2) pipelined fetch port.
//   clk, rst                          : clock, asynchronous active-high reset
//   req_valid/req_ready/req_addr      : fetch request (byte address)
//   rsp_valid/rsp_ready               : fetch response handshake
//   rsp_instr/rsp_fault               : fetched word, misaligned/out-of-range flag
//   ld_en/ld_addr/ld_data/ld_be       : program-load write with byte enables
//   fault_cnt                         : saturating count of accepted faulted fetches
module instr_mem_pipe
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned LATENCY   = 1,
  parameter logic [31:0] INIT_WORD = NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic        rsp_fault,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  input  logic [3:0]  ld_be,
  output logic [FAULT_CNT_W-1:0] fault_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Contents come up as INIT_WORD at elaboration; rst never touches them.
  word_t mem [DEPTH] = '{default: INIT_WORD};

  logic [AW-1:0] req_idx;
  logic [AW-1:0] ld_idx;
  logic          req_fault;
  logic          ld_in_range;
  word_t         rd_data;
  logic          s0_ready;
  logic          accept;
  logic          unused_ld_lsb;

  logic [FAULT_CNT_W-1:0] fault_cnt_q;

  assign req_idx     = req_addr[AW+1:2];
  assign ld_idx      = ld_addr[AW+1:2];
  assign req_fault   = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= 30'(DEPTH));
  assign ld_in_range = ld_addr[31:2] < 30'(DEPTH);
  assign rd_data     = req_fault ? INIT_WORD : mem[req_idx];
  assign unused_ld_lsb = ^ld_addr[1:0];

  // Loads own the cycle; draining stages are unaffected.
  assign req_ready = !ld_en && s0_ready;
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (ld_en && ld_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (ld_be[b]) begin
          mem[ld_idx][8*b +: 8] <= ld_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_cnt_q <= '0;
    end else if (accept && req_fault && (fault_cnt_q != '1)) begin
      fault_cnt_q <= fault_cnt_q + 1'b1;
    end
  end

  assign fault_cnt = fault_cnt_q;

  // The memory read happens at the accepting edge: the first stage captures
  // rd_data, so in-flight words are immune to later loads.
  if (LATENCY == 1) begin : g_lat1
    imem_pipe_stage #(
      .INIT_WORD (INIT_WORD)
    ) u_stage1 (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (req_valid && !ld_en),
      .in_ready_o  (s0_ready),
      .in_instr_i  (rd_data),
      .in_fault_i  (req_fault),
      .out_valid_o (rsp_valid),
      .out_ready_i (rsp_ready),
      .out_instr_o (rsp_instr),
      .out_fault_o (rsp_fault)
    );
  end else begin : g_lat2
    logic        s1_valid;
    logic        s1_ready;
    logic [31:0] s1_instr;
    logic        s1_fault;

    imem_pipe_stage #(
      .INIT_WORD (INIT_WORD)
    ) u_stage1 (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (req_valid && !ld_en),
      .in_ready_o  (s0_ready),
      .in_instr_i  (rd_data),
      .in_fault_i  (req_fault),
      .out_valid_o (s1_valid),
      .out_ready_i (s1_ready),
      .out_instr_o (s1_instr),
      .out_fault_o (s1_fault)
    );

    imem_pipe_stage #(
      .INIT_WORD (INIT_WORD)
    ) u_stage2 (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (s1_valid),
      .in_ready_o  (s1_ready),
      .in_instr_i  (s1_instr),
      .in_fault_i  (s1_fault),
      .out_valid_o (rsp_valid),
      .out_ready_i (rsp_ready),
      .out_instr_o (rsp_instr),
      .out_fault_o (rsp_fault)
    );
  end

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Directed self-checking bench for instr_mem_pipe (LATENCY=2, DEPTH=256).
module tb_instr_mem_pipe;

  localparam int unsigned LAT = 2;
  localparam int unsigned DEP = 256;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic        rsp_fault;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic [3:0]  ld_be;
  logic [7:0]  fault_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q [$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        fault;
  } vec_t;

  vec_t tbl [8];

  instr_mem_pipe #(
    .DEPTH     (DEP),
    .LATENCY   (LAT),
    .INIT_WORD (32'h00000013)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_fault (rsp_fault),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_be     (ld_be),
    .fault_cnt (fault_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One load cycle; req_ready must be low while ld_en is high.
  task automatic load(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    ld_en = 1'b1; ld_addr = a; ld_data = d; ld_be = be;
    #1;
    chk("ready_low_during_load", {31'b0, req_ready}, 32'd0);
    step();
    ld_en = 1'b0; ld_be = 4'h0;
  endtask

  // Single fetch with rsp_ready high, bounded waits.
  task automatic fetch1(input string nm, input logic [31:0] a, input logic [31:0] ei,
                        input logic ef);
    int  n;
    bit  got;
    req_valid = 1'b1; req_addr = a; rsp_ready = 1'b1;
    #1;
    n = 0;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    if (!req_ready) chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
    step();
    req_valid = 1'b0;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (rsp_valid) begin
        chk({nm, "_instr"}, rsp_instr, ei);
        chk({nm, "_fault"}, {31'b0, rsp_fault}, {31'b0, ef});
        got = 1;
      end
      step();
    end
    if (!got) chk({nm, "_rsp_timeout"}, 32'd0, 32'd1);
  endtask

  // Consume everything with rsp_ready high and compare against exp_q in order.
  task automatic drain(input string nm);
    rsp_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk({nm, "_extra_rsp"}, rsp_instr, 32'hxxxxxxxx);
        end else begin
          chk({nm, "_order"}, rsp_instr, exp_q.pop_front());
        end
      end
      step();
    end
    chk({nm, "_missing"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int i, j, cyc, first_acc, first_rsp, last_rsp, stalls, acc;
    bit acc_now, take;
    logic [31:0] t_instr;
    logic        t_fault;

    tbl[0] = '{32'h0000_0000, 32'h1111_1111, 1'b0};
    tbl[1] = '{32'h0000_0004, 32'h2222_2222, 1'b0};
    tbl[2] = '{32'h0000_0008, 32'h3333_3333, 1'b0};
    tbl[3] = '{32'h0000_000C, 32'h4444_4444, 1'b0};
    tbl[4] = '{32'h0000_0010, 32'h0000_0013, 1'b0};
    tbl[5] = '{32'h0000_0006, 32'h0000_0013, 1'b1};
    tbl[6] = '{32'h0000_0400, 32'h0000_0013, 1'b1};
    tbl[7] = '{32'h0000_03FC, 32'h0000_0013, 1'b0};

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; ld_be = '0;
    #1;
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_rsp_instr", rsp_instr, 32'h0000_0013);
    chk("reset_rsp_fault", {31'b0, rsp_fault}, 32'd0);
    chk("reset_fault_cnt", {24'b0, fault_cnt}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("ready_after_reset", {31'b0, req_ready}, 32'd1);

    for (int w = 0; w < 4; w++) begin
      load(32'(w * 4), 32'h1111_1111 * 32'(w + 1), 4'hF);
    end

    // Back-to-back table fetch with a scoreboard on order, latency, throughput.
    i = 0; j = 0; cyc = 0; first_acc = -1; first_rsp = -1; last_rsp = -1; stalls = 0;
    rsp_ready = 1'b1;
    while (j < 8 && cyc < 60) begin
      req_valid = (i < 8);
      req_addr  = (i < 8) ? tbl[i].addr : 32'h0;
      #1;
      acc_now = req_valid && req_ready;
      if (req_valid && !req_ready) stalls++;
      take    = rsp_valid && rsp_ready;
      t_instr = rsp_instr;
      t_fault = rsp_fault;
      if (acc_now && first_acc < 0) first_acc = cyc;
      if (take) begin
        if (first_rsp < 0) first_rsp = cyc;
        last_rsp = cyc;
        chk($sformatf("tbl%0d_instr", j), t_instr, tbl[j].instr);
        chk($sformatf("tbl%0d_fault", j), {31'b0, t_fault}, {31'b0, tbl[j].fault});
        j++;
      end
      step();
      if (acc_now) i++;
      cyc++;
    end
    req_valid = 1'b0;
    chk("tbl_all_responses", j, 32'd8);
    chk("tbl_first_latency", first_rsp - first_acc, LAT);
    chk("tbl_one_per_cycle", last_rsp - first_rsp, 32'd7);
    chk("tbl_no_stalls", stalls, 32'd0);
    chk("fault_cnt_two", {24'b0, fault_cnt}, 32'd2);

    // Output stall: 0x8 sits at the output, pipeline fills, nothing lost.
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h8;
    #1;
    chk("stall_acc0_ready", {31'b0, req_ready}, 32'd1);
    step();
    req_addr = 32'hC;
    #1;
    chk("stall_acc1_ready", {31'b0, req_ready}, 32'd1);
    step();
    req_addr = 32'h0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_valid", {31'b0, rsp_valid}, 32'd1);
      chk("stall_instr", rsp_instr, 32'h3333_3333);
      chk("stall_ready_low", {31'b0, req_ready}, 32'd0);
      step();
    end
    req_valid = 1'b0;
    exp_q.push_back(32'h3333_3333);
    exp_q.push_back(32'h4444_4444);
    drain("stall_drain");

    // Byte-enable load; fetch issued the cycle right after the load.
    load(32'h4, 32'hAABB_CCDD, 4'b0101);
    fetch1("be_merge", 32'h4, 32'h22BB_22DD, 1'b0);
    load(32'h8, 32'hFFFF_FFFF, 4'b0000);
    fetch1("be_zero", 32'h8, 32'h3333_3333, 1'b0);
    load(32'h400, 32'hDEAD_BEEF, 4'hF);
    fetch1("ld_out_of_range", 32'h0, 32'h1111_1111, 1'b0);

    // In-flight response keeps the word read at acceptance.
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'hC;
    step();
    req_valid = 1'b0;
    load(32'hC, 32'h5555_5555, 4'hF);
    exp_q.push_back(32'h4444_4444);
    drain("inflight_old");
    fetch1("inflight_new", 32'hC, 32'h5555_5555, 1'b0);

    // Saturation of the fault counter.
    req_valid = 1'b1; req_addr = 32'h2; rsp_ready = 1'b1; acc = 0;
    for (int k = 0; k < 400 && acc < 300; k++) begin
      #1;
      if (req_ready) acc++;
      step();
    end
    req_valid = 1'b0;
    repeat (4) step();
    chk("sat_accepts", acc, 32'd300);
    chk("fault_cnt_sat", {24'b0, fault_cnt}, 32'd255);

    // Asynchronous reset with two responses in flight.
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h0;
    step();
    req_addr = 32'h4;
    step();
    req_valid = 1'b0;
    chk("pre_reset_valid", {31'b0, rsp_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("async_rst_instr", rsp_instr, 32'h0000_0013);
    chk("async_rst_fault", {31'b0, rsp_fault}, 32'd0);
    chk("async_rst_cnt", {24'b0, fault_cnt}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("release_ready", {31'b0, req_ready}, 32'd1);
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("no_stale_rsp", {31'b0, rsp_valid}, 32'd0);
      step();
    end
    fetch1("mem_kept", 32'h4, 32'h22BB_22DD, 1'b0);
    fetch1("unloaded_word", 32'h10, 32'h0000_0013, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
